// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the core's shared instruction/data memory.
// The data port wins contention unless it has won STREAK_MAX contended grants in a row.
// One transaction is in flight at a time. Stores finish in their grant cycle. Reads hold
// the memory until the response comes back.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STREAK_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);
    localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT);

    typedef enum logic {StIdle, StWait} state_e;

    state_e     state_q, state_d;
    logic [2:0] lat_q, lat_d;
    logic [3:0] streak_q, streak_d;
    logic       owner_q, owner_d;     // 1 = data port owns the outstanding read
    logic       grant_d, grant_if;
    logic       last_beat;

    // Winner selection; grants happen only in IDLE and never while reset is held.
    always_comb begin
        grant_d  = 1'b0;
        grant_if = 1'b0;
        if (!reset && state_q == StIdle) begin
            if (d_req && (!if_req || streak_q != STREAK_LIM)) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    // The response is due in the WAIT cycle where the counter steps from 1 to 0.
    assign last_beat = (state_q == StWait) && (lat_q == 3'd1);

    // State register plus latency counter, streak counter and read owner.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            lat_q    <= 3'd0;
            streak_q <= 4'd0;
            owner_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            streak_q <= streak_d;
            owner_q  <= owner_d;
        end
    end

    // Next-state logic: any read grant moves to WAIT, and the final latency beat returns to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant_if || (grant_d && !d_we)) state_d = StWait;
            StWait:  if (lat_q == 3'd1) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values for latency counter, streak counter and owner.
    always_comb begin
        lat_d    = lat_q;
        streak_d = streak_q;
        owner_d  = owner_q;
        if (state_q == StWait) begin
            lat_d = lat_q - 3'd1;
        end
        if (grant_if) begin
            streak_d = 4'd0;
            owner_d  = 1'b0;
            lat_d    = LAT_LOAD;
        end
        if (grant_d) begin
            // Only contended data wins extend the streak.
            if (if_req) begin
                streak_d = (streak_q == STREAK_LIM) ? streak_q : streak_q + 4'd1;
            end else begin
                streak_d = 4'd0;
            end
            if (!d_we) begin
                owner_d = 1'b1;
                lat_d   = LAT_LOAD;
            end
        end
    end

    // Output logic: memory strobe and fields from the winner, and read data routed to its owner.
    always_comb begin
        if_gnt    = grant_if;
        d_gnt     = grant_d;
        mem_req   = grant_if | grant_d;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        busy      = !reset && (state_q == StWait);
        if (grant_d) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
        end else if (grant_if) begin
            mem_addr  = if_addr;
            mem_be    = '1;
        end
        if (!reset && last_beat) begin
            if (owner_q) begin
                d_rvalid = 1'b1;
                d_rdata  = mem_rdata;
            end else begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end
        end
    end

endmodule
